ppu_pixel_fifo: RTL and testbench

- Parametrised pixel FIFO and mixer stage for the PPU pixel-transfer path.
- Accepts 8-pixel background/window rows from the fetcher and merges 8-pixel object rows onto the FIFO head using priority rules.
- Discards fine-scroll pixels at line start and emits one tagged pixel per cycle to the palette/LCD stage.
- Generalises the fixed 16-entry, 2-bpp, single-palette-per-source FIFO: depth, bits per pixel and palette count are parameters; object merging and BG priority are new.

---
 rtl/ppu_pkg.sv | 37 +++
 rtl/ppu_obj_mixer.sv | 42 ++++
 rtl/ppu_pixel_fifo.sv | 193 +++++++++++++++++++
 tb/tb_ppu_pixel_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU pixel-path constants, source tags and the bitplane row unpacker.
// Widths here are upper bounds; modules narrow results to their own BPP.
package ppu_pkg;

  localparam int ROW_PX  = 8;
  localparam int MAX_BPP = 8;

  // Entry layout is {color[BPP], pal[PALW], is_obj, prio}.
  localparam int ENTRY_FLAG_W = 2;

  function automatic int entry_width(input int bpp, input int palw);
    return bpp + palw + ENTRY_FLAG_W;
  endfunction

  // Pixel source tags, kept for the DMG wrapper.
  typedef enum logic [1:0] {
    SRC_BG = 2'd0,
    SRC_WD = 2'd1,
    SRC_O0 = 2'd2,
    SRC_O1 = 2'd3
  } src_e;

  // Pixel j (0 = leftmost) takes bit 7-j of every plane; plane p is bit p of the colour.
  function automatic logic [MAX_BPP-1:0] unpack_row(
    input logic [ROW_PX*MAX_BPP-1:0] planes,
    input int                        bpp,
    input int                        j
  );
    logic [MAX_BPP-1:0] c;
    c = '0;
    for (int p = 0; p < MAX_BPP; p++) begin
      if (p < bpp) c[p] = planes[ROW_PX*p + ROW_PX - 1 - j];
    end
    return c;
  endfunction

endpackage

// File: rtl/ppu_obj_mixer.sv
// Combinational 8-pixel object-over-FIFO-head merge.
// An object pixel lands only on a non-object entry and only where BG priority does not hide it.
module ppu_obj_mixer
  import ppu_pkg::*;
#(
  parameter int BPP  = 2,
  parameter int PALW = 3
) (
  input  logic [ROW_PX*BPP-1:0]  in_color,
  input  logic [ROW_PX*PALW-1:0] in_pal,
  input  logic [ROW_PX-1:0]      in_is_obj,
  input  logic [ROW_PX-1:0]      in_prio,
  input  logic [ROW_PX*BPP-1:0]  obj_planes,
  input  logic [PALW-1:0]        obj_pal,
  input  logic                   obj_behind,
  output logic [ROW_PX*BPP-1:0]  out_color,
  output logic [ROW_PX*PALW-1:0] out_pal,
  output logic [ROW_PX-1:0]      out_is_obj,
  output logic [ROW_PX-1:0]      out_prio
);

  genvar gi;
  generate
    for (gi = 0; gi < ROW_PX; gi++) begin : g_px
      logic [BPP-1:0] obj_color;
      logic [BPP-1:0] fifo_color;
      logic           take;

      assign obj_color  = BPP'(unpack_row((ROW_PX*MAX_BPP)'(obj_planes), BPP, gi));
      assign fifo_color = in_color[gi*BPP +: BPP];
      // Earlier (lower-X) object pixels already in the FIFO always win.
      assign take = (obj_color != '0) && !in_is_obj[gi]
                    && !((obj_behind || in_prio[gi]) && (fifo_color != '0));

      assign out_color[gi*BPP +: BPP]   = take ? obj_color : fifo_color;
      assign out_pal[gi*PALW +: PALW]   = take ? obj_pal : in_pal[gi*PALW +: PALW];
      assign out_is_obj[gi]             = take ? 1'b1 : in_is_obj[gi];
      assign out_prio[gi]               = take ? obj_behind : in_prio[gi];
    end
  endgenerate

endmodule

// File: rtl/ppu_pixel_fifo.sv
// Pixel FIFO and mixer: takes 8-pixel BG rows, merges object rows onto the head,
// drops fine-scroll pixels after a line clear and emits one registered pixel per pop.
module ppu_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int BPP      = 2,
  parameter int PALW     = 3,
  parameter int MIN_FILL = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [2:0]                 scx_fine,
  input  logic                       bg_valid,
  output logic                       bg_ready,
  input  logic [ROW_PX*BPP-1:0]      bg_planes,
  input  logic [PALW-1:0]            bg_pal,
  input  logic                       bg_prio,
  input  logic                       obj_valid,
  output logic                       obj_ready,
  input  logic [ROW_PX*BPP-1:0]      obj_planes,
  input  logic [PALW-1:0]            obj_pal,
  input  logic                       obj_behind,
  input  logic                       pop_en,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       px_valid,
  output logic [BPP-1:0]             px_color,
  output logic [PALW-1:0]            px_pal,
  output logic                       px_is_obj
);

  localparam int CW = $clog2(DEPTH+1);

  logic [BPP-1:0]  color_reg [DEPTH];
  logic [BPP-1:0]  color_next [DEPTH];
  logic [PALW-1:0] pal_reg [DEPTH];
  logic [PALW-1:0] pal_next [DEPTH];
  logic            obj_reg [DEPTH];
  logic            obj_next [DEPTH];
  logic            prio_reg [DEPTH];
  logic            prio_next [DEPTH];

  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic [2:0]      discard_reg;
  logic            px_valid_reg;
  logic [BPP-1:0]  px_color_reg;
  logic [PALW-1:0] px_pal_reg;
  logic            px_is_obj_reg;

  logic push;
  logic merge;
  logic pop;
  int   push_base;

  assign bg_ready  = (count_reg <= CW'(DEPTH - ROW_PX)) && !clear;
  assign obj_ready = (count_reg >= CW'(ROW_PX)) && !clear;
  assign push      = bg_valid && bg_ready;
  assign merge     = obj_valid && obj_ready;
  assign pop       = pop_en && (count_reg > CW'(MIN_FILL)) && !merge && !clear;

  logic [BPP-1:0]         row_color [ROW_PX];
  logic [ROW_PX*BPP-1:0]  head_color;
  logic [ROW_PX*PALW-1:0] head_pal;
  logic [ROW_PX-1:0]      head_obj;
  logic [ROW_PX-1:0]      head_prio;
  logic [ROW_PX*BPP-1:0]  mix_color;
  logic [ROW_PX*PALW-1:0] mix_pal;
  logic [ROW_PX-1:0]      mix_obj;
  logic [ROW_PX-1:0]      mix_prio;

  genvar gi;
  generate
    for (gi = 0; gi < ROW_PX; gi++) begin : g_row
      assign row_color[gi]               = BPP'(unpack_row((ROW_PX*MAX_BPP)'(bg_planes), BPP, gi));
      assign head_color[gi*BPP +: BPP]   = color_reg[gi];
      assign head_pal[gi*PALW +: PALW]   = pal_reg[gi];
      assign head_obj[gi]                = obj_reg[gi];
      assign head_prio[gi]               = prio_reg[gi];
    end
  endgenerate

  ppu_obj_mixer #(
    .BPP  (BPP),
    .PALW (PALW)
  ) u_mixer (
    .in_color   (head_color),
    .in_pal     (head_pal),
    .in_is_obj  (head_obj),
    .in_prio    (head_prio),
    .obj_planes (obj_planes),
    .obj_pal    (obj_pal),
    .obj_behind (obj_behind),
    .out_color  (mix_color),
    .out_pal    (mix_pal),
    .out_is_obj (mix_obj),
    .out_prio   (mix_prio)
  );

  // Merge and pop are mutually exclusive; a push lands one slot lower when it rides a pop.
  always_comb begin
    color_next = color_reg;
    pal_next   = pal_reg;
    obj_next   = obj_reg;
    prio_next  = prio_reg;
    count_next = count_reg;
    push_base  = int'(count_reg);

    if (merge) begin
      for (int i = 0; i < ROW_PX; i++) begin
        color_next[i] = mix_color[i*BPP +: BPP];
        pal_next[i]   = mix_pal[i*PALW +: PALW];
        obj_next[i]   = mix_obj[i];
        prio_next[i]  = mix_prio[i];
      end
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        color_next[i] = color_reg[i+1];
        pal_next[i]   = pal_reg[i+1];
        obj_next[i]   = obj_reg[i+1];
        prio_next[i]  = prio_reg[i+1];
      end
      color_next[DEPTH-1] = '0;
      pal_next[DEPTH-1]   = '0;
      obj_next[DEPTH-1]   = 1'b0;
      prio_next[DEPTH-1]  = 1'b0;
      push_base  = int'(count_reg) - 1;
      count_next = count_reg - CW'(1);
    end

    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = 0; k < ROW_PX; k++) begin
          if (i == push_base + k) begin
            color_next[i] = row_color[k];
            pal_next[i]   = bg_pal;
            obj_next[i]   = 1'b0;
            prio_next[i]  = bg_prio;
          end
        end
      end
      count_next = count_next + CW'(ROW_PX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        color_reg[i] <= '0;
        pal_reg[i]   <= '0;
        obj_reg[i]   <= 1'b0;
        prio_reg[i]  <= 1'b0;
      end
      count_reg     <= '0;
      discard_reg   <= '0;
      px_valid_reg  <= 1'b0;
      px_color_reg  <= '0;
      px_pal_reg    <= '0;
      px_is_obj_reg <= 1'b0;
    end else if (clear) begin
      count_reg    <= '0;
      discard_reg  <= scx_fine;
      px_valid_reg <= 1'b0;
    end else begin
      color_reg <= color_next;
      pal_reg   <= pal_next;
      obj_reg   <= obj_next;
      prio_reg  <= prio_next;
      count_reg <= count_next;
      if (pop) begin
        if (discard_reg != 3'd0) begin
          discard_reg  <= discard_reg - 3'd1;
          px_valid_reg <= 1'b0;
        end else begin
          px_valid_reg  <= 1'b1;
          px_color_reg  <= color_reg[0];
          px_pal_reg    <= pal_reg[0];
          px_is_obj_reg <= obj_reg[0];
        end
      end else begin
        px_valid_reg <= 1'b0;
      end
    end
  end

  assign count     = count_reg;
  assign px_valid  = px_valid_reg;
  assign px_color  = px_color_reg;
  assign px_pal    = px_pal_reg;
  assign px_is_obj = px_is_obj_reg;

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Bench for ppu_pixel_fifo: directed vector table on a 16-deep FIFO, then random
// traffic on a 32-deep FIFO checked against a queue-based pixel model.
module tb_ppu_pixel_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, bg_valid, bg_prio, obj_valid, obj_behind, pop_en;
  logic [2:0]  scx_fine, bg_pal, obj_pal;
  logic [15:0] bg_planes, obj_planes;

  logic       bg_ready16, obj_ready16, px_valid16, px_is_obj16;
  logic [4:0] count16;
  logic [1:0] px_color16;
  logic [2:0] px_pal16;
  logic       bg_ready32, obj_ready32, px_valid32, px_is_obj32;
  logic [5:0] count32;
  logic [1:0] px_color32;
  logic [2:0] px_pal32;

  ppu_pixel_fifo #(.DEPTH(16), .BPP(2), .PALW(3), .MIN_FILL(8)) u_dut16 (
    .clk(clk), .reset(reset), .clear(clear), .scx_fine(scx_fine),
    .bg_valid(bg_valid), .bg_ready(bg_ready16), .bg_planes(bg_planes), .bg_pal(bg_pal), .bg_prio(bg_prio),
    .obj_valid(obj_valid), .obj_ready(obj_ready16), .obj_planes(obj_planes), .obj_pal(obj_pal),
    .obj_behind(obj_behind), .pop_en(pop_en), .count(count16), .px_valid(px_valid16),
    .px_color(px_color16), .px_pal(px_pal16), .px_is_obj(px_is_obj16)
  );

  ppu_pixel_fifo #(.DEPTH(32), .BPP(2), .PALW(3), .MIN_FILL(8)) u_dut32 (
    .clk(clk), .reset(reset), .clear(clear), .scx_fine(scx_fine),
    .bg_valid(bg_valid), .bg_ready(bg_ready32), .bg_planes(bg_planes), .bg_pal(bg_pal), .bg_prio(bg_prio),
    .obj_valid(obj_valid), .obj_ready(obj_ready32), .obj_planes(obj_planes), .obj_pal(obj_pal),
    .obj_behind(obj_behind), .pop_en(pop_en), .count(count32), .px_valid(px_valid32),
    .px_color(px_color32), .px_pal(px_pal32), .px_is_obj(px_is_obj32)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  typedef struct {
    int clr, scx, bgv, bgp, bpal, bprio, objv, objp, opal, ob, pe;
    int ebr, eor, ecnt, epv, ecol, epal, eobj;
  } vec_t;

  function automatic vec_t mk(input int clr, scx, bgv, bgp, bpal, bprio, objv, objp, opal, ob, pe,
                              input int ebr, eor, ecnt, epv, ecol, epal, eobj);
    vec_t v;
    v.clr = clr; v.scx = scx; v.bgv = bgv; v.bgp = bgp; v.bpal = bpal; v.bprio = bprio;
    v.objv = objv; v.objp = objp; v.opal = opal; v.ob = ob; v.pe = pe;
    v.ebr = ebr; v.eor = eor; v.ecnt = ecnt; v.epv = epv; v.ecol = ecol; v.epal = epal; v.eobj = eobj;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    clear      = v.clr[0];
    scx_fine   = 3'(v.scx);
    bg_valid   = v.bgv[0];
    bg_planes  = 16'(v.bgp);
    bg_pal     = 3'(v.bpal);
    bg_prio    = v.bprio[0];
    obj_valid  = v.objv[0];
    obj_planes = 16'(v.objp);
    obj_pal    = 3'(v.opal);
    obj_behind = v.ob[0];
    pop_en     = v.pe[0];
  endtask

  // Reference pixel model: queue of pixels, head at index 0.
  typedef struct { int col; int pal; bit isobj; bit prio; } ent_t;
  ent_t mq[$];
  int   m_disc, m_pv, m_col, m_pal, m_obj;

  function automatic int pix(input logic [15:0] planes, input int j);
    return int'(planes[15-j]) * 2 + int'(planes[7-j]);
  endfunction

  localparam int A = 16'hF0AA, B = 16'h0F33, CZ = 16'h0000, DF = 16'hFFFF;

  vec_t tbl[$];
  vec_t idle;
  int   acol[8] = '{3, 2, 3, 2, 1, 0, 1, 0};
  int   h_col, h_pal, h_obj;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    drive(idle);
    reset = 1'b0;
    #1;
    chk("reset_count", int'(count16), 0);
    chk("reset_px_valid", int'(px_valid16), 0);
    chk("reset_px_color", int'(px_color16), 0);
    chk("reset_bg_ready", int'(bg_ready16), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    //         clr scx bgv bgp bpal bprio objv objp opal ob pe | ebr eor cnt pv col pal obj
    tbl.push_back(mk(1,0,1,A,1,0, 1,16'h00FF,5,0, 1, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,A,1,0, 0,0,0,0, 0, 1,0,8,0,0,0,0));
    tbl.push_back(mk(0,0,1,A,2,0, 0,0,0,0, 0, 1,1,16,0,0,0,0));
    tbl.push_back(mk(0,0,1,A,2,0, 0,0,0,0, 0, 0,1,16,0,0,0,0));
    tbl.push_back(mk(1,3,0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,A,1,0, 0,0,0,0, 0, 1,0,8,0,0,0,0));
    tbl.push_back(mk(0,0,1,B,2,1, 0,0,0,0, 0, 1,1,16,0,0,0,0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,15-k,0,0,0,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,12-k,1,acol[3+k],1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 1,1,8,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,16'h00FF,5,0, 1, 1,1,8,0,0,0,0));
    tbl.push_back(mk(0,0,1,CZ,3,0, 0,0,0,0, 1, 1,1,16,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,15,1,1,5,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,14,1,1,5,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,13,1,1,2,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,12,1,1,2,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,11,1,2,2,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,10,1,2,2,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,9,1,3,2,0));
    tbl.push_back(mk(0,0,1,DF,4,0, 0,0,0,0, 1, 0,1,8,1,3,2,0));
    tbl.push_back(mk(0,0,1,DF,4,0, 0,0,0,0, 1, 1,1,16,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,16'h00F0,6,0, 1, 0,1,16,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,16'hFFFF,7,0, 1, 0,1,16,0,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,15-k,1,1,6,1));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,11-k,1,3,7,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 1,1,8,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,16'h00FF,5,1, 1, 1,1,8,0,0,0,0));
    tbl.push_back(mk(0,0,1,CZ,0,0, 0,0,0,0, 1, 1,1,16,0,0,0,0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 0,1,15-k,1,3,4,0));
    tbl.push_back(mk(1,0,1,A,1,0, 1,16'h00FF,5,0, 1, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));

    h_col = 0; h_pal = 0; h_obj = 0;
    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n]);
      #1;
      chk($sformatf("v%0d_bg_ready", n), int'(bg_ready16), tbl[n].ebr);
      chk($sformatf("v%0d_obj_ready", n), int'(obj_ready16), tbl[n].eor);
      @(posedge clk);
      #1;
      if (tbl[n].epv != 0) begin
        h_col = tbl[n].ecol; h_pal = tbl[n].epal; h_obj = tbl[n].eobj;
      end
      chk($sformatf("v%0d_count", n), int'(count16), tbl[n].ecnt);
      chk($sformatf("v%0d_px_valid", n), int'(px_valid16), tbl[n].epv);
      chk($sformatf("v%0d_px_color", n), int'(px_color16), h_col);
      chk($sformatf("v%0d_px_pal", n), int'(px_pal16), h_pal);
      chk($sformatf("v%0d_px_is_obj", n), int'(px_is_obj16), h_obj);
      $display("vec %0d cnt=%0d pv=%0b col=%0d pal=%0d obj=%0b", n, count16, px_valid16,
               px_color16, px_pal16, px_is_obj16);
      @(negedge clk);
    end

    // Reset dropped between clock edges while the FIFO holds data.
    drive(mk(0,0,1,A,1,0, 0,0,0,0, 0, 0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    chk("pre_reset_count", int'(count16), 8);
    @(negedge clk);
    drive(idle);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_count16", int'(count16), 0);
    chk("async_reset_px_valid16", int'(px_valid16), 0);
    chk("async_reset_count32", int'(count32), 0);
    chk("async_reset_px_color32", int'(px_color32), 0);
    @(negedge clk);
    reset = 1'b1;
    mq.delete();
    m_disc = 0; m_pv = 0; m_col = 0; m_pal = 0; m_obj = 0;

    for (int n = 0; n < 1500; n++) begin
      vec_t v;
      int sz, br, orr, mrg, psh, pp;
      v = mk(($urandom_range(0, 63) == 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 1),
             int'($urandom_range(0, 65535)), $urandom_range(0, 7), $urandom_range(0, 1),
             ($urandom_range(0, 5) == 0) ? 1 : 0, int'($urandom_range(0, 65535)),
             $urandom_range(0, 7), $urandom_range(0, 1),
             ($urandom_range(0, 3) != 0) ? 1 : 0, 0,0,0,0,0,0,0);
      drive(v);
      sz  = mq.size();
      br  = (sz <= 24 && v.clr == 0) ? 1 : 0;
      orr = (sz >= 8 && v.clr == 0) ? 1 : 0;
      mrg = (v.objv != 0 && orr != 0) ? 1 : 0;
      psh = (v.bgv != 0 && br != 0) ? 1 : 0;
      pp  = (v.pe != 0 && sz > 8 && mrg == 0 && v.clr == 0) ? 1 : 0;
      #1;
      chk($sformatf("r%0d_bg_ready", n), int'(bg_ready32), br);
      chk($sformatf("r%0d_obj_ready", n), int'(obj_ready32), orr);
      @(posedge clk);
      if (v.clr != 0) begin
        mq.delete();
        m_disc = v.scx;
        m_pv = 0;
      end else begin
        if (mrg != 0) begin
          for (int j = 0; j < 8; j++) begin
            int oc;
            oc = pix(16'(v.objp), j);
            if (oc != 0 && !mq[j].isobj && !((v.ob != 0 || mq[j].prio) && mq[j].col != 0))
              mq[j] = '{oc, v.opal, 1'b1, v.ob[0]};
          end
        end
        if (pp != 0) begin
          ent_t e;
          e = mq.pop_front();
          if (m_disc > 0) begin
            m_disc--;
            m_pv = 0;
          end else begin
            m_pv = 1; m_col = e.col; m_pal = e.pal; m_obj = int'(e.isobj);
          end
        end else begin
          m_pv = 0;
        end
        if (psh != 0)
          for (int j = 0; j < 8; j++) mq.push_back('{pix(16'(v.bgp), j), v.bpal, 1'b0, v.bprio[0]});
      end
      #1;
      chk($sformatf("r%0d_count", n), int'(count32), mq.size());
      chk($sformatf("r%0d_px_valid", n), int'(px_valid32), m_pv);
      chk($sformatf("r%0d_px_color", n), int'(px_color32), m_col);
      chk($sformatf("r%0d_px_pal", n), int'(px_pal32), m_pal);
      chk($sformatf("r%0d_px_is_obj", n), int'(px_is_obj32), m_obj);
      $display("rnd %0d clr=%0d push=%0d merge=%0d pop=%0d cnt=%0d pv=%0b col=%0d pal=%0d obj=%0b",
               n, v.clr, psh, mrg, pp, count32, px_valid32, px_color32, px_pal32, px_is_obj32);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
